// File: rtl/sha256_padder.sv
// sha256_padder
// Byte-stream to 512-bit block front end for sha256_core. Appends the 0x80
// marker, zero fill and the 64-bit big-endian message bit length, then
// presents each block, tagged with first/last flags, through a valid/ready
// handshake. One message is in flight at a time and the block is built in a
// single buffer, so input and output are never active in the same cycle.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_data    message byte
//   in_valid   input beat valid
//   in_last    beat ends the message
//   in_empty   last beat carries no byte (in_data ignored)
//   in_ready   padder accepts a beat this cycle
//   out_block  padded block, byte 0 at [511:504], byte 63 at [7:0]
//   out_valid  out_block valid
//   out_first  block is the first of its message
//   out_last   block is the final block of its message
//   out_ready  consumer takes the block
//
// State table:
//   S_FILL | accept message bytes into the buffer
//   S_PAD  | write the 0x80 marker, plus the length field if it fits
//   S_LEN  | write the length field into an otherwise empty block
//   S_EMIT | present the buffer downstream and wait for out_ready

module sha256_padder #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    input  logic         in_empty,
    output logic         in_ready,
    output logic [511:0] out_block,
    output logic         out_valid,
    output logic         out_first,
    output logic         out_last,
    input  logic         out_ready
);

    typedef enum logic [1:0] {
        S_FILL,
        S_PAD,
        S_LEN,
        S_EMIT
    } state_t;

    state_t             state;
    logic [511:0]       buffer;
    logic [6:0]         idx;
    logic [LEN_W-1:0]   bit_len;
    logic               first_flag;
    logic               final_flag;
    logic               pad_pend;
    logic               len_pend;

    logic [63:0]        len_field;
    logic [8:0]         wr_pos;

    always_comb begin
        len_field = 64'(bit_len);
        // Bit offset of the low bit of byte idx; byte 0 sits at the top.
        wr_pos    = 9'd504 - {idx[5:0], 3'b000};
        in_ready  = (state == S_FILL) && !rst;
        out_valid = (state == S_EMIT);
        out_first = (state == S_EMIT) && first_flag;
        out_last  = (state == S_EMIT) && final_flag;
        out_block = buffer;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FILL;
            buffer     <= '0;
            idx        <= '0;
            bit_len    <= '0;
            first_flag <= 1'b1;
            final_flag <= 1'b0;
            pad_pend   <= 1'b0;
            len_pend   <= 1'b0;
        end else begin
            case (state)
                S_FILL: begin
                    if (in_valid) begin
                        if (in_last && in_empty) begin
                            state <= S_PAD;
                        end else begin
                            buffer[wr_pos +: 8] <= in_data;
                            idx                 <= idx + 7'd1;
                            bit_len             <= bit_len + LEN_W'(8);
                            if (idx == 7'd63) begin
                                // Block full; a last byte here still owes
                                // a marker block afterwards.
                                state      <= S_EMIT;
                                final_flag <= 1'b0;
                                len_pend   <= 1'b0;
                                pad_pend   <= in_last;
                            end else if (in_last) begin
                                state <= S_PAD;
                            end
                        end
                    end
                end

                S_PAD: begin
                    buffer[wr_pos +: 8] <= 8'h80;
                    idx                 <= idx + 7'd1;
                    pad_pend            <= 1'b0;
                    state               <= S_EMIT;
                    if (idx <= 7'd55) begin
                        // Marker ends at or before byte 56: length fits.
                        buffer[63:0] <= len_field;
                        final_flag   <= 1'b1;
                        len_pend     <= 1'b0;
                    end else begin
                        final_flag <= 1'b0;
                        len_pend   <= 1'b1;
                    end
                end

                S_LEN: begin
                    buffer[63:0] <= len_field;
                    final_flag   <= 1'b1;
                    len_pend     <= 1'b0;
                    state        <= S_EMIT;
                end

                S_EMIT: begin
                    if (out_ready) begin
                        buffer     <= '0;
                        idx        <= '0;
                        first_flag <= 1'b0;
                        if (pad_pend) begin
                            state <= S_PAD;
                        end else if (len_pend) begin
                            state <= S_LEN;
                        end else begin
                            state <= S_FILL;
                            if (final_flag) begin
                                first_flag <= 1'b1;
                                bit_len    <= '0;
                            end
                        end
                    end
                end

                default: state <= S_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder
// Randomised scoreboard bench for sha256_padder. Messages are padded by a
// byte-level reference model into expected blocks queued at issue time; an
// independent monitor pops and compares every transferred block.

module tb_sha256_padder;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        logic [511:0] blk;
        logic         first;
        logic         last;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_empty;
    logic         in_ready;
    logic [511:0] out_block;
    logic         out_valid;
    logic         out_first;
    logic         out_last;
    logic         out_ready;

    sha256_padder #(.LEN_W(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_empty  (in_empty),
        .in_ready  (in_ready),
        .out_block (out_block),
        .out_valid (out_valid),
        .out_first (out_first),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int ready_mode = 2;   // 0 random, 1 held low, 2 held high

    exp_t         sb[$];
    logic [511:0] seen_block;
    logic         seen_first;
    logic         seen_last;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic note_fail(input string name);
        checks++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Reference padding: append marker, zero fill to 56 mod 64, 8 length bytes.
    task automatic push_expected(input byte_q_t msg);
        byte_q_t     p;
        logic [63:0] len;
        exp_t        e;
        int          nblk;
        p   = msg;
        len = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(8'(len >> (8 * i)));
        nblk = p.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            e.blk = '0;
            for (int j = 0; j < 64; j++) e.blk = {e.blk[503:0], p[64 * b + j]};
            e.first = (b == 0);
            e.last  = (b == nblk - 1);
            sb.push_back(e);
        end
    endtask

    // out_ready driver, changes just after the rising edge.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = ($urandom % 4) != 0;
                1:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: compares each transferred block, checks stability under stall.
    initial begin
        logic         hold;
        logic [511:0] h_blk;
        logic         h_first;
        logic         h_last;
        exp_t         e;
        hold = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("stall_valid", 512'(out_valid), 512'(1));
                    chk("stall_block", out_block, h_blk);
                    chk("stall_first", 512'(out_first), 512'(h_first));
                    chk("stall_last", 512'(out_last), 512'(h_last));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        note_fail("unexpected_block");
                    end else begin
                        e = sb.pop_front();
                        chk("block", out_block, e.blk);
                        chk("first", 512'(out_first), 512'(e.first));
                        chk("last", 512'(out_last), 512'(e.last));
                    end
                    seen_block = out_block;
                    seen_first = out_first;
                    seen_last  = out_last;
                end
                hold    = out_valid && !out_ready;
                h_blk   = out_block;
                h_first = out_first;
                h_last  = out_last;
            end
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic last, input logic empty);
        int w;
        @(negedge clk);
        if (($urandom % 4) == 0) @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_empty = empty;
        w = 0;
        while (!in_ready && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) note_fail("in_ready_wait");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_empty = 1'b0;
    endtask

    task automatic send_msg(input byte_q_t msg, input logic empty_tail);
        int n;
        n = msg.size();
        push_expected(msg);
        for (int i = 0; i < n; i++)
            send_beat(msg[i], (i == n - 1) && !empty_tail, 1'b0);
        if (n == 0 || empty_tail) send_beat(8'($urandom), 1'b1, 1'b1);
        if (n <= 55) begin
            // Single final block: valid appears in the second cycle after accept.
            @(negedge clk);
            chk("latency_c1", 512'(out_valid), 512'(0));
            @(negedge clk);
            chk("latency_c2", 512'(out_valid), 512'(1));
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((sb.size() != 0 || out_valid) && w < 5000) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0 || out_valid) note_fail("drain");
        @(negedge clk);
    endtask

    function automatic byte_q_t abc();
        byte_q_t q;
        q = '{8'h61, 8'h62, 8'h63};
        return q;
    endfunction

    function automatic byte_q_t fill_msg(input int n, input int kind);
        byte_q_t q;
        for (int i = 0; i < n; i++)
            q.push_back(kind == 0 ? 8'h00 : (kind == 1 ? 8'(i) : 8'($urandom)));
        return q;
    endfunction

    localparam logic [511:0] ABC_BLK   = {32'h61626380, 416'h0, 64'h18};
    localparam logic [511:0] EMPTY_BLK = {8'h80, 504'h0};
    localparam logic [511:0] LEN56_BLK = {448'h0, 64'h1C0};
    localparam logic [511:0] LEN64_BLK = {8'h80, 440'h0, 64'h200};

    initial begin
        int w;
        int n;
        byte_q_t q;
        rst      = 1'b1;
        in_data  = 8'h00;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_empty = 1'b0;
        seen_block = '0;
        seen_first = 1'b0;
        seen_last  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 512'(in_ready), 512'(0));
        chk("rst_out_valid", 512'(out_valid), 512'(0));
        chk("rst_out_first", 512'(out_first), 512'(0));
        chk("rst_out_last", 512'(out_last), 512'(0));
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 512'(in_ready), 512'(1));

        // "abc"
        send_msg(abc(), 1'b0);
        drain();
        chk("abc_block", seen_block, ABC_BLK);
        chk("abc_first", 512'(seen_first), 512'(1));
        chk("abc_last", 512'(seen_last), 512'(1));

        // empty message
        q = {};
        send_msg(q, 1'b0);
        drain();
        chk("empty_block", seen_block, EMPTY_BLK);

        ready_mode = 0;
        send_msg(fill_msg(55, 0), 1'b0);
        drain();
        send_msg(fill_msg(56, 0), 1'b0);
        drain();
        chk("len56_block2", seen_block, LEN56_BLK);
        chk("len56_first", 512'(seen_first), 512'(0));
        send_msg(fill_msg(64, 1), 1'b0);
        drain();
        chk("len64_block2", seen_block, LEN64_BLK);
        chk("len64_last", 512'(seen_last), 512'(1));

        // Backpressure on "abc", then another "abc" right behind it.
        ready_mode = 1;
        send_msg(abc(), 1'b0);
        w = 0;
        while (!out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!out_valid) note_fail("bp_wait_valid");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 512'(in_ready), 512'(0));
        end
        ready_mode = 0;
        drain();
        send_msg(abc(), 1'b0);
        drain();
        chk("abc2_block", seen_block, ABC_BLK);
        chk("abc2_first", 512'(seen_first), 512'(1));

        // Reset mid-fill after 10 bytes: no output, next message clean.
        q = fill_msg(10, 2);
        for (int i = 0; i < 10; i++) send_beat(q[i], 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 512'(in_ready), 512'(0));
        @(negedge clk);
        chk("midrst_out_valid", 512'(out_valid), 512'(0));
        rst = 1'b0;
        send_msg(abc(), 1'b0);
        drain();
        chk("midrst_abc_block", seen_block, ABC_BLK);

        // Randomised messages, including boundary sizes and empty tail beats.
        for (int m = 0; m < 30; m++) begin
            case (m % 6)
                0: n = 55 + int'($urandom_range(0, 2));
                1: n = 63 + int'($urandom_range(0, 2));
                2: n = 119 + int'($urandom_range(0, 2));
                3: n = 127 + int'($urandom_range(0, 2));
                default: n = int'($urandom_range(0, 150));
            endcase
            send_msg(fill_msg(n, 2), ($urandom % 3) == 0);
            drain();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation bound expired");
        $fatal(1, "timeout");
    end

endmodule
